// File: rtl/cic_pkg.sv
// Shared constants and elaboration/runtime helpers for the CIC decimator.
package cic_pkg;

   // Largest decimation rate the shift logic is sized for; requests above it saturate.
   localparam int unsigned MAX_RATE = 65535;

   // Accumulator width needed so the final comb result never aliases.
   function automatic int unsigned acc_width(input int unsigned w_in, input int unsigned n,
                                             input int unsigned rate_w);
      return w_in + n * rate_w;
   endfunction

   // Ceiling log2 with clog2(0) = clog2(1) = 0; fixed trip count keeps it synthesizable.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < {32'd0, v}) r = i + 1;
      end
      return r;
   endfunction

   // Gain-normalising right shift: N * clog2(R).
   function automatic int unsigned shift_for_rate(input int unsigned rate, input int unsigned n);
      return n * clog2(rate);
   endfunction

   // Map a requested rate onto 1..MAX_RATE (0 behaves as 1).
   function automatic int unsigned sat_rate(input int unsigned rate);
      if (rate == 0) return 1;
      if (rate > MAX_RATE) return MAX_RATE;
      return rate;
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC comb section: out = x - x_prev, advancing only on strobe_in.
module cic_comb_stage #(
   parameter int unsigned WIDTH = 48
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic signed [WIDTH-1:0] in,
   input  logic                    strobe_in,
   output logic signed [WIDTH-1:0] out,
   output logic                    strobe_out
);

   logic signed [WIDTH-1:0] dly_q, dly_d;
   logic signed [WIDTH-1:0] out_q, out_d;
   logic                    vld_q, vld_d;

   // Difference against the previous decimated sample; flush drops history and in-flight data.
   always_comb begin
      dly_d = dly_q;
      out_d = out_q;
      vld_d = 1'b0;
      if (flush) begin
         dly_d = '0;
      end else if (strobe_in) begin
         out_d = in - dly_q;
         dly_d = in;
         vld_d = 1'b1;
      end
   end

   // Stage state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dly_q <= '0;
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         dly_q <= dly_d;
         out_q <= out_d;
         vld_q <= vld_d;
      end
   end

   assign out        = out_q;
   assign strobe_out = vld_q;

endmodule

// File: rtl/cic_decimator.sv
// Strobed, variable-rate N-stage CIC decimator with per-rate gain normalisation.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int unsigned WIDTH_IN   = 16,
   parameter int unsigned WIDTH_OUT  = 24,
   parameter int unsigned N          = 4,
   parameter int unsigned RATE_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [RATE_WIDTH-1:0]       rate,
   input  logic                        rate_stb,
   input  logic signed [WIDTH_IN-1:0]  in,
   input  logic                        strobe_in,
   output logic signed [WIDTH_OUT-1:0] out,
   output logic                        strobe_out
);

   localparam int unsigned ACC = acc_width(WIDTH_IN, N, RATE_WIDTH);
   localparam int unsigned GW  = WIDTH_OUT - WIDTH_IN;
   localparam int unsigned SW  = $clog2(N * RATE_WIDTH + 1);

   logic [RATE_WIDTH-1:0]       rate_q, rate_d;
   logic [SW-1:0]               shift_q, shift_d;
   logic [RATE_WIDTH-1:0]       count_q, count_d;
   logic                        dec_q, dec_d;
   logic signed [ACC-1:0]       integ_q [N];
   logic signed [ACC-1:0]       integ_d [N];
   logic signed [ACC-1:0]       cap_q, cap_d;
   logic                        cap_vld_q, cap_vld_d;
   logic signed [WIDTH_OUT-1:0] out_q, out_d;
   logic                        stb_q, stb_d;
   logic signed [ACC+GW-1:0]    wide;
   int unsigned                 rate_eff;

   logic signed [ACC-1:0]       comb_data [N+1];
   logic                        comb_vld  [N+1];

   // Rate/shift latch and decimation counter; rate_stb wins over a coincident sample.
   always_comb begin
      rate_eff = sat_rate(32'(rate));
      rate_d   = rate_q;
      shift_d  = shift_q;
      count_d  = count_q;
      dec_d    = 1'b0;
      if (rate_stb) begin
         rate_d  = RATE_WIDTH'(rate_eff);
         shift_d = SW'(shift_for_rate(rate_eff, N));
         count_d = '0;
      end else if (strobe_in) begin
         if (count_q == rate_q - RATE_WIDTH'(1)) begin
            count_d = '0;
            dec_d   = 1'b1;
         end else begin
            count_d = count_q + RATE_WIDTH'(1);
         end
      end
   end

   // Integrator cascade; each stage adds the previous stage's pre-update value.
   always_comb begin
      integ_d = integ_q;
      if (rate_stb) begin
         for (int i = 0; i < N; i++) integ_d[i] = '0;
      end else if (strobe_in) begin
         integ_d[0] = integ_q[0] + ACC'(in);
         for (int i = 1; i < N; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
      end
   end

   // Capture the last integrator one cycle after the decimate pulse.
   always_comb begin
      cap_d     = dec_q ? integ_q[N-1] : cap_q;
      cap_vld_d = dec_q & ~rate_stb;
   end

   assign comb_data[0] = cap_q;
   assign comb_vld[0]  = cap_vld_q;

   for (genvar k = 0; k < N; k++) begin : g_comb
      cic_comb_stage #(
         .WIDTH (ACC)
      ) u_comb (
         .clk        (clk),
         .reset_n    (reset_n),
         .flush      (rate_stb),
         .in         (comb_data[k]),
         .strobe_in  (comb_vld[k]),
         .out        (comb_data[k+1]),
         .strobe_out (comb_vld[k+1])
      );
   end

   // Scale to output width: append fraction LSBs, then divide out the R^N gain.
   always_comb begin
      wide  = (ACC + GW)'(comb_data[N]) <<< GW;
      stb_d = comb_vld[N] & ~rate_stb;
      out_d = stb_d ? WIDTH_OUT'(wide >>> shift_q) : out_q;
   end

   // All top-level state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rate_q    <= RATE_WIDTH'(1);
         shift_q   <= '0;
         count_q   <= '0;
         dec_q     <= 1'b0;
         cap_q     <= '0;
         cap_vld_q <= 1'b0;
         out_q     <= '0;
         stb_q     <= 1'b0;
         for (int i = 0; i < N; i++) integ_q[i] <= '0;
      end else begin
         rate_q    <= rate_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         dec_q     <= dec_d;
         cap_q     <= cap_d;
         cap_vld_q <= cap_vld_d;
         out_q     <= out_d;
         stb_q     <= stb_d;
         for (int i = 0; i < N; i++) integ_q[i] <= integ_d[i];
      end
   end

   assign out        = out_q;
   assign strobe_out = stb_q;

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Strobed, variable-rate CIC decimator for the receive DSP chain.
- Sits directly upstream of the sigma-delta rounding stage. It turns a strobed WIDTH_IN sample stream into a decimated WIDTH_OUT stream, and its out/strobe_out drive that stage's in/strobe_in directly.
- Gain is normalised by a per-rate shift. The extra WIDTH_OUT-WIDTH_IN LSBs carry fraction for downstream rounding.

Parameters:
- WIDTH_IN, 16, signed input sample width.
- WIDTH_OUT, 24, signed output width; must be >= WIDTH_IN.
- N, 4, number of integrator and comb stages.
- RATE_WIDTH, 8, width of the rate input; legal rates are 1..2^RATE_WIDTH-1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- rate  in  RATE_WIDTH  decimation rate, unsigned; 0 is treated as 1.
- rate_stb  in  1  loads rate and flushes the filter.
- in  in  WIDTH_IN  signed input sample.
- strobe_in  in  1  in is valid this cycle.
- out  out  WIDTH_OUT  signed decimated sample.
- strobe_out  out  1  out is valid; single-cycle pulse.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values (applied while reset_n is low, with no clock edge needed):
  - out=0, strobe_out=0.
  - All integrators, comb delays and the pipeline valid bits = 0.
  - Decimation counter = 0.
  - Latched rate R = 1, latched shift S = 0.
- Accumulator width: ACC = WIDTH_IN + N*RATE_WIDTH. All integrator and comb arithmetic is two's-complement modulo 2^ACC. Wrap in the integrators is intentional and is cancelled by the combs.
- Integrators:
  - On strobe_in: integ[0] <= integ[0] + sext(in).
  - integ[i] <= integ[i] + integ[i-1] for i = 1..N-1, using the pre-update value of integ[i-1].
  - No change on other cycles.
- Decimation counter:
  - Increments on each strobe_in.
  - On a strobe_in with count == R-1: count <= 0, and a decimate pulse is registered.
- Decimate capture: on the cycle after the decimate pulse, comb_in <= integ[N-1] (the value after the triggering update).
- Combs:
  - N stages, one register per stage, each advancing only on its own valid bit.
  - c[k] = x - d[k], then d[k] <= x.
- Output stage (registered):
  - out <= ((comb_out <<< (WIDTH_OUT-WIDTH_IN)) >>> S), truncated to WIDTH_OUT bits, where >>> is arithmetic.
  - S = N*clog2(R), with clog2(1) = 0.
  - The result never overflows: gain is R^N/2^S <= 1.
- Latency: strobe_out is high exactly N+2 clocks after the clk edge that samples the final strobe_in of a decimation group.
  - out holds its value between strobes.
  - strobe_in may be asserted every clock.
- Output rate: exactly one strobe_out per R strobe_in.
- rate_stb:
  - Loads R = max(rate,1) and recomputes S.
  - Synchronously clears integrators, comb delays, counter and all in-flight valid bits.
  - strobe_out is 0 on the next clock; out keeps its last value.
  - rate_stb has priority over a coincident strobe_in; that sample is discarded.
- Transient: after reset or rate_stb, the first N outputs are a transient. Output is steady-state from output N+1 onward for a constant input.

Decomposition:
- Shared package cic_pkg holds:
  - ACC width function.
  - clog2 function.
  - Shift-computation function shift_for_rate(rate, N).
  - Saturating constant MAX_RATE.
- One sub-module: cic_comb_stage, parameterised on WIDTH.
  - Ports: clk, reset_n, flush, in, strobe_in, out, strobe_out.
  - Instantiated N times in a generate loop.
- Integrators stay inline in the top level.

Test Plan:
- DC, rate 1: rate_stb with rate=1, then in=1000 on every clock -> strobe_out on every clock after the N+2 latency; out = 256000 from the 5th output onward.
- DC, rate 4: rate=4, in=1000 strobed every clock -> one strobe_out per 4 strobe_in; first strobe_out exactly 6 clocks after the 4th strobe_in; steady out = 256000.
- Non-power-of-two rate: rate=3 (S=8, gain 81/256), in=1000 -> steady out = 81000. Repeat with strobe_in every 3rd clock; expect an identical output sequence.
- Full-scale negative: rate=255, in=-32768 continuous -> steady out = -8258303 (0x81FD01), with no wrap in the output.
- rate_stb mid-stream: at rate 4, assert rate_stb with rate=2 coincident with a strobe_in and one output in flight -> no strobe_out for that in-flight result; out holds; the next strobe_out follows 2 fresh strobe_in plus 6 clocks.
- Asynchronous reset mid-group: drop reset_n between clock edges while strobe_out=1 -> out=0 and strobe_out=0 immediately. After release, behaviour matches power-up: R=1 pass-through.
